// File: rtl/bus_rr_arbiter_bcast.sv
// Packet bus arbiter/router: grants one agent FIFO, pops its head packet,
// then pushes it to the decoded destination agent(s) or drops it.
module bus_rr_arbiter_bcast #(
  parameter int              DRVRS      = 16,
  parameter int              PCKG_SZ    = 16,
  parameter int              ID_W       = 8,
  parameter logic [ID_W-1:0] BROADCAST  = 8'hFF,
  parameter bit              RR_MODE    = 1'b1,
  parameter bit              BCAST_SELF = 1'b0,
  parameter int              CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DRVRS-1:0]         pndng,
  input  logic [DRVRS*PCKG_SZ-1:0] D_pop,
  output logic [DRVRS-1:0]         pop,
  output logic [DRVRS-1:0]         push,
  output logic [PCKG_SZ-1:0]       D_push,
  output logic                     busy,
  output logic                     err_drop,
  output logic [CNT_W-1:0]         pkt_cnt,
  output logic [CNT_W-1:0]         err_cnt
);

  localparam int GW = (DRVRS > 1) ? $clog2(DRVRS) : 1;
  localparam logic [DRVRS-1:0] ONE = DRVRS'(1);
  localparam logic [ID_W:0] NUM = (ID_W+1)'(DRVRS);

  typedef enum logic [1:0] {IDLE, POP, PUSH} state_t;

  state_t             state;
  logic [GW-1:0]      gnt;
  logic [GW-1:0]      last_gnt;
  logic [GW-1:0]      pick;
  logic               pick_found;
  int                 pick_idx;
  logic [PCKG_SZ-1:0] pkt;
  logic [ID_W-1:0]    dst;

  assign dst  = pkt[PCKG_SZ-1 -: ID_W];
  assign busy = (state != IDLE);

  // Round-robin scans from the agent after the last grant, wrapping.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    pick_idx   = 0;
    if (RR_MODE) begin
      for (int i = 1; i <= DRVRS; i++) begin
        pick_idx = int'(last_gnt) + i;
        if (pick_idx >= DRVRS)
          pick_idx = pick_idx - DRVRS;
        if (!pick_found && pndng[pick_idx]) begin
          pick_found = 1'b1;
          pick       = GW'(pick_idx);
        end
      end
    end else begin
      for (int i = DRVRS - 1; i >= 0; i--)
        if (pndng[i])
          pick = GW'(i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      gnt      <= '0;
      last_gnt <= GW'(DRVRS - 1);
      pkt      <= '0;
      pop      <= '0;
      push     <= '0;
      D_push   <= '0;
      err_drop <= 1'b0;
      pkt_cnt  <= '0;
      err_cnt  <= '0;
    end else begin
      pop      <= '0;
      push     <= '0;
      err_drop <= 1'b0;
      unique case (state)
        IDLE: begin
          if (|pndng) begin
            gnt   <= pick;
            state <= POP;
          end
        end
        POP: begin
          if (pndng[gnt]) begin
            pop      <= ONE << gnt;
            pkt      <= D_pop[gnt*PCKG_SZ +: PCKG_SZ];
            last_gnt <= gnt;
            state    <= PUSH;
          end else begin
            state <= IDLE;
          end
        end
        PUSH: begin
          D_push <= pkt;
          state  <= IDLE;
          if (dst == BROADCAST) begin
            push    <= BCAST_SELF ? '1 : ~(ONE << gnt);
            pkt_cnt <= pkt_cnt + CNT_W'(1);
          end else if ({1'b0, dst} < NUM) begin
            push    <= ONE << dst;
            pkt_cnt <= pkt_cnt + CNT_W'(1);
          end else begin
            err_drop <= 1'b1;
            err_cnt  <= err_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
